mult_div_unit: RTL and testbench

- Iterative HI/LO multiply/divide unit directly downstream of the register file. Consumes the two read-data buses (RD1 → src_a, RD2 → src_b) for MULT/MULTU/DIV/DIVU.
- Holds the architectural HI and LO registers, which feed MFHI/MFLO back toward the writeback mux.
- Stalls the single-cycle core via busy while an operation runs.

---
 rtl/mult_div_unit.sv | 163 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Define MDU_FAST_MULT_EN to make MULT/MULTU a single-edge combinational multiply.
module mult_div_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wd,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int unsigned W2 = 2 * WIDTH;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [1:0]       state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [W2-1:0]    acc, acc_d;
   logic [WIDTH-1:0] shreg, shreg_d;
   logic [WIDTH-1:0] opb, opb_d;
   logic             sign_a, sign_a_d;
   logic             sign_b, sign_b_d;
   logic             is_div, is_div_d;
   logic             b_zero, b_zero_d;
   logic [WIDTH-1:0] hi_d, lo_d;
   logic             busy_d, done_d;

   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] rem_sub;
   logic             neg_q;
   logic [W2-1:0]    prod_fix;
   logic [WIDTH-1:0] q_fix, r_fix;

`ifdef MDU_FAST_MULT_EN
   logic [W2-1:0] ext_a, ext_b, fast_p;
   // Sign- or zero-extend to 2W so a single truncated product serves both MULT and MULTU
   assign ext_a  = op[0] ? {{WIDTH{1'b0}}, src_a} : {{WIDTH{src_a[WIDTH-1]}}, src_a};
   assign ext_b  = op[0] ? {{WIDTH{1'b0}}, src_b} : {{WIDTH{src_b[WIDTH-1]}}, src_b};
   assign fast_p = ext_a * ext_b;
`endif

   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      acc_d    = acc;
      shreg_d  = shreg;
      opb_d    = opb;
      sign_a_d = sign_a;
      sign_b_d = sign_b;
      is_div_d = is_div;
      b_zero_d = b_zero;
      hi_d     = hi;
      lo_d     = lo;
      done_d   = 1'b0;

      // Divide keeps its partial remainder in acc[W-1:0]; shreg shifts dividend out, quotient in
      rem_sh   = {acc[WIDTH-1:0], shreg[WIDTH-1]};
      rem_sub  = WIDTH'(rem_sh - {1'b0, opb});
      neg_q    = sign_a ^ sign_b;
      prod_fix = neg_q ? (W2'(0) - acc) : acc;
      q_fix    = neg_q ? (WIDTH'(0) - shreg) : shreg;
      r_fix    = sign_a ? (WIDTH'(0) - acc[WIDTH-1:0]) : acc[WIDTH-1:0];

      case (state)
         S_IDLE: begin
            if (start) begin
               sign_a_d = ~op[0] & src_a[WIDTH-1];
               sign_b_d = ~op[0] & src_b[WIDTH-1];
               shreg_d  = sign_a_d ? (WIDTH'(0) - src_a) : src_a;
               opb_d    = sign_b_d ? (WIDTH'(0) - src_b) : src_b;
               is_div_d = op[1];
               b_zero_d = (src_b == {WIDTH{1'b0}});
               acc_d    = W2'(0);
               cnt_d    = CNT_W'(0);
               state_d  = S_RUN;
`ifdef MDU_FAST_MULT_EN
               if (!op[1]) begin
                  state_d    = S_IDLE;
                  {hi_d, lo_d} = fast_p;
                  done_d     = 1'b1;
               end
`endif
            end else begin
               if (hi_we) hi_d = wd;
               if (lo_we) lo_d = wd;
            end
         end
         S_RUN: begin
            cnt_d = cnt + CNT_W'(1);
            if (is_div) begin
               if (rem_sh >= {1'b0, opb}) begin
                  acc_d   = {{WIDTH{1'b0}}, rem_sub};
                  shreg_d = {shreg[WIDTH-2:0], 1'b1};
               end else begin
                  acc_d   = {{WIDTH{1'b0}}, rem_sh[WIDTH-1:0]};
                  shreg_d = {shreg[WIDTH-2:0], 1'b0};
               end
            end else begin
               acc_d   = {acc[W2-2:0], 1'b0} +
                         (shreg[WIDTH-1] ? {{WIDTH{1'b0}}, opb} : W2'(0));
               shreg_d = {shreg[WIDTH-2:0], 1'b0};
            end
            if (cnt == CNT_LAST) state_d = S_FIX;
         end
         S_FIX: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            if (is_div) begin
               lo_d = b_zero ? {WIDTH{1'b1}} : q_fix;
               hi_d = r_fix;
            end else begin
               {hi_d, lo_d} = prod_fix;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= CNT_W'(0);
         acc    <= W2'(0);
         shreg  <= WIDTH'(0);
         opb    <= WIDTH'(0);
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         is_div <= 1'b0;
         b_zero <= 1'b0;
         hi     <= WIDTH'(0);
         lo     <= WIDTH'(0);
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         acc    <= acc_d;
         shreg  <= shreg_d;
         opb    <= opb_d;
         sign_a <= sign_a_d;
         sign_b <= sign_b_d;
         is_div <= is_div_d;
         b_zero <= b_zero_d;
         hi     <= hi_d;
         lo     <= lo_d;
         busy   <= busy_d;
         done   <= done_d;
      end
   end
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, random ops against an
// arithmetic reference model, and hand-written hazard sequences.
module tb_mult_div_unit;
   localparam int unsigned W = 32;
`ifdef MDU_FAST_MULT_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n, start, hi_we, lo_we;
   logic [1:0]   op;
   logic [W-1:0] src_a, src_b, wd;
   logic         busy, done;
   logic [W-1:0] hi, lo;

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_hl;

   mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [1:0] op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on 64-bit values
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         2'b00: return 64'(sa * sb);
         2'b01: return {32'b0, a} * {32'b0, b};
         2'b10: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {32'(r), 32'(q)};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {32'(a % b), 32'(a / b)};
         end
      endcase
   endfunction

   function automatic int exp_lat(input logic [1:0] o);
      return (FAST && !o[1]) ? 1 : 34;
   endfunction

   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(negedge clk);
      start = 1'b0;
      src_a = $urandom; src_b = $urandom;
   endtask

   task automatic wait_done(input int first, output int edges, output int bcyc);
      edges = first;
      bcyc  = 0;
      while (done !== 1'b1 && edges < 100) begin
         if (busy === 1'b1) bcyc++;
         @(negedge clk);
         edges++;
      end
   endtask

   task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
      int edges, bcyc;
      issue(o, a, b);
      wait_done(1, edges, bcyc);
      check({name, " latency"}, 64'(edges), 64'(exp_lat(o)));
      check({name, " busy cycles"}, 64'(bcyc), 64'(exp_lat(o) - 1));
      check({name, " busy at done"}, 64'(busy), 64'(0));
      check({name, " hi/lo"}, {hi, lo}, exp);
      @(negedge clk);
      check({name, " done single"}, 64'(done), 64'(0));
      exp_hl = exp;
   endtask

   initial begin
      vec_t vecs[8];
      int edges, bcyc, ndone, nbusy;
      logic [1:0] ro;
      logic [31:0] ra, rb;

      vecs[0] = '{"multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[1] = '{"mult_neg7x3", 2'b00, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
      vecs[2] = '{"mult_m1xm1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1};
      vecs[3] = '{"div_neg7by2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[4] = '{"divu_100by7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14};
      vecs[5] = '{"divu_by0", 2'b11, 32'h55, 32'h0, 32'h55, 32'hFFFF_FFFF};
      vecs[6] = '{"div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000};
      vecs[7] = '{"div_neg_by0", 2'b10, 32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFFF};

      rst_n = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
      hi_we = 1'b0; lo_we = 1'b0; wd = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("reset hi", 64'(hi), 64'(0));
      check("reset lo", 64'(lo), 64'(0));
      check("reset busy", 64'(busy), 64'(0));
      check("reset done", 64'(done), 64'(0));

      // MT writes
      lo_we = 1'b1; wd = 32'h1234_5678;
      @(negedge clk);
      lo_we = 1'b0;
      check("mtlo lo", 64'(lo), 64'(32'h1234_5678));
      check("mtlo hi", 64'(hi), 64'(0));
      check("mtlo done", 64'(done), 64'(0));
      hi_we = 1'b1; lo_we = 1'b1; wd = 32'hA5A5_5A5A;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
      check("mthi+mtlo", {hi, lo}, {32'hA5A5_5A5A, 32'hA5A5_5A5A});
      check("mthi+mtlo done", 64'(done), 64'(0));
      exp_hl = {hi, lo};

      for (int i = 0; i < 8; i++) begin
         check({vecs[i].name, " model"}, model(vecs[i].op, vecs[i].a, vecs[i].b),
               {vecs[i].hi, vecs[i].lo});
         run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});
      end

      for (int i = 0; i < 30; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
         if ($urandom_range(0, 3) == 0) rb = rb & 32'hFF;
         run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, model(ro, ra, rb));
      end

      // start and MTHI pulsed mid-RUN must be ignored
      ra = $urandom; rb = 32'($urandom) | 32'h1;
      issue(2'b11, ra, rb);
      repeat (5) @(negedge clk);
      start = 1'b1; op = 2'b01; src_a = 32'd3; src_b = 32'd5; hi_we = 1'b1; wd = 32'hDEAD_BEEF;
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0;
      check("hazard hold hi/lo", {hi, lo}, exp_hl);
      check("hazard busy", 64'(busy), 64'(1));
      wait_done(7, edges, bcyc);
      check("hazard latency", 64'(edges), 64'(34));
      check("hazard result", {hi, lo}, model(2'b11, ra, rb));
      exp_hl = {hi, lo};
      repeat (2) @(negedge clk);
      check("hazard no queued op", 64'(busy), 64'(0));

      // start wins over MTLO in the same idle cycle
      ra = $urandom; rb = 32'($urandom) & 32'hFFFF;
      @(negedge clk);
      start = 1'b1; op = 2'b10; src_a = ra; src_b = rb; lo_we = 1'b1; wd = 32'h1111_2222;
      @(negedge clk);
      start = 1'b0; lo_we = 1'b0;
      check("start+mtlo lo held", {hi, lo}, exp_hl);
      wait_done(1, edges, bcyc);
      check("start+mtlo latency", 64'(edges), 64'(34));
      check("start+mtlo result", {hi, lo}, model(2'b10, ra, rb));

      // reset mid-RUN discards the operation
      issue(2'b01, 32'hFFFF_FFFF, 32'h1234_5678);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midrun reset hi/lo", {hi, lo}, 64'(0));
      check("midrun reset busy", 64'(busy), 64'(0));
      check("midrun reset done", 64'(done), 64'(0));
      ndone = 0; nbusy = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
         if (busy === 1'b1) nbusy++;
      end
      check("after reset no done", 64'(ndone), 64'(0));
      check("after reset no busy", 64'(nbusy), 64'(0));
      check("after reset hi/lo", {hi, lo}, 64'(0));
      exp_hl = 64'(0);
      run_op("post reset divu", 2'b11, 32'd1000, 32'd33, model(2'b11, 32'd1000, 32'd33));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
